ifft64_r2mdc_seq: RTL



---
 rtl/ifft64_r2mdc_seq_if.sv | 30 +++
 rtl/ifft64_r2mdc_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ifft64_r2mdc_seq_if.sv
// ------------------------------------------------------------------
// ifft64_r2mdc_seq_if: sequencer <-> datapath control bundle (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

interface ifft64_r2mdc_seq_if #(
   parameter int ADDR_W = 10
);
   logic              Start;
   logic [ADDR_W-1:0] bank_addr;
   logic [4:0]        lane_sel;
   logic              in_valid;
   logic [24:0]       tw_addr;
   logic [4:0]        sw;
   logic              start_check;
   logic              busy;
   logic              done;

   modport master (
      input  Start,
      output bank_addr, lane_sel, in_valid, tw_addr, sw, start_check, busy, done
   );

   modport slave (
      output Start,
      input  bank_addr, lane_sel, in_valid, tw_addr, sw, start_check, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/ifft64_r2mdc_seq.sv
// ------------------------------------------------------------------
// ifft64_r2mdc_seq: lane/frame issue, twiddle and commutator sequencing
// for the 64-point radix-2 MDC IFFT pipeline (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module ifft64_r2mdc_seq #(
   parameter int N_FRAMES  = 1000,
   parameter int ADDR_W    = 10,
   parameter int STAGE_LAT = 6,
   parameter int PIPE_LAT  = 36
) (
   input  logic                       CLK,
   input  logic                       ARST,
   ifft64_r2mdc_seq_if.master         bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_FRAME = ADDR_W'(N_FRAMES - 1);

   state_t              state;
   logic [ADDR_W-1:0]   bank;
   logic [4:0]          lane;
   logic                in_valid;
   logic                busy;
   logic                done;
   logic [PIPE_LAT-1:0] dline;   // dline[i] = in_valid delayed i+1 cycles
   logic [24:0]         tw_all;
   logic [4:0]          sw_all;

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         state    <= IDLE;
         bank     <= '0;
         lane     <= '0;
         in_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               bank <= '0;
               lane <= '0;
               if (bus.Start) begin
                  state    <= RUN;
                  in_valid <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               lane <= lane + 5'd1;
               if (lane == 5'd31) begin
                  if (bank == LAST_FRAME) begin
                     state    <= DRAIN;
                     in_valid <= 1'b0;
                     lane     <= '0;
                  end else begin
                     bank <= bank + ADDR_W'(1);
                  end
               end
            end
            DRAIN: begin
               // The issue window is contiguous, so the trailing edge of the
               // delay line marks the final start_check cycle.
               if (dline[PIPE_LAT-1] && !dline[PIPE_LAT-2]) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (!bus.Start) begin
                  state <= IDLE;
                  bank  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) dline <= '0;
      else      dline <= {dline[PIPE_LAT-2:0], in_valid};
   end

   // Stage 0 counts exactly the issued lanes, so its twiddle index is lane_sel.
   assign tw_all[4:0] = lane;

   generate
      for (genvar k = 1; k <= 5; k++) begin : g_stage
         localparam int TAP = k * STAGE_LAT;
         logic       v_now;
         logic       v_nxt;
         logic [4:0] cnt;
         logic [4:0] cnt_nxt;
         logic [4:0] tw_q;
         logic       sw_q;

         assign v_now = dline[TAP-1];
         if (TAP == 1) begin : g_first
            assign v_nxt = in_valid;
         end else begin : g_tap
            assign v_nxt = dline[TAP-2];
         end

         assign cnt_nxt = (state == IDLE) ? 5'd0 : (v_now ? cnt + 5'd1 : cnt);

         // Outputs are registered from next-cycle values so they line up with v_k.
         always_ff @(posedge CLK or posedge ARST) begin
            if (ARST) begin
               cnt  <= '0;
               tw_q <= '0;
               sw_q <= 1'b0;
            end else begin
               cnt  <= cnt_nxt;
               tw_q <= v_nxt ? 5'(cnt_nxt << k) : 5'd0;
               sw_q <= v_nxt & cnt_nxt[5-k];
            end
         end

         assign sw_all[k-1] = sw_q;
         if (k < 5) begin : g_tw
            assign tw_all[5*k +: 5] = tw_q;
         end
      end
   endgenerate

   assign bus.bank_addr   = bank;
   assign bus.lane_sel    = lane;
   assign bus.in_valid    = in_valid;
   assign bus.tw_addr     = tw_all;
   assign bus.sw          = sw_all;
   assign bus.start_check = dline[PIPE_LAT-1];
   assign bus.busy        = busy;
   assign bus.done        = done;

endmodule

`default_nettype wire
